rv_trace_capture: RTL and testbench
===================================

Name: rv_trace_capture

Overview:
Parametrised run controller and circular trace buffer for the RV32I core. It samples the core's PC, opcode and ALU-result outputs every clock and keeps a rolling pre-trigger history. It stops the run on a PC trigger, on a halt (PC stuck), or on a cycle timeout. The buffer can be read back in oldest-first order by the bench or a debug port.

Parameters:
XLEN, 32, width of PC and ALU data
DEPTH, 16, buffer entries; power of 2, at least 4
POST, 8, entries stored after the trigger, counting the trigger entry; range 1..DEPTH
TIMEOUT, 2500, maximum samples per run; 0 disables the timeout
HALT_CNT, 4, number of consecutive identical PC samples that counts as a halt; at least 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that arms a run
trig_en  in  1  enables the PC trigger
trig_pc  in  XLEN  trigger PC value
pc_in  in  XLEN  core PC
op_in  in  32  core opcode
alu_in  in  XLEN  core ALU result
rd_idx  in  log2(DEPTH)  readout index; 0 = oldest entry
rd_pc  out  XLEN  PC at rd_idx
rd_op  out  32  opcode at rd_idx
rd_alu  out  XLEN  ALU result at rd_idx
fill  out  clog2(DEPTH+1)  number of valid entries
state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
done  out  1  high when state==DONE
stop_cause  out  2  00 none, 01 trigger, 10 halt, 11 timeout
cycles  out  32  samples written in the current run; saturates at 2^32-1

Behaviour:
- Reset:
  - state=IDLE; fill=0; stop_cause=00; cycles=0; done=0.
  - Write pointer, post counter, halt counter and prev_pc register all cleared.
  - Buffer RAM is not reset.
  - Reset mid-run aborts the run with the same result.
- IDLE, DONE:
  - No writes.
  - start moves to ARMED on the next cycle.
  - The same edge clears wr_ptr, fill, cycles, stop_cause and the halt counter.
  - start is ignored in ARMED and POST.
- ARMED, POST, every cycle:
  - Write {pc_in, op_in, alu_in} at wr_ptr.
  - wr_ptr wraps mod DEPTH.
  - fill increments and saturates at DEPTH; once full, the oldest entry is overwritten.
  - cycles increments.
  - prev_pc is set to pc_in.
- Trigger:
  - Active only in ARMED: trig_en && pc_in==trig_pc.
  - The trigger sample is written.
  - If POST==1, go to DONE with cause 01.
  - Otherwise go to POST with the post counter at POST-1.
  - Trigger matches in POST are ignored.
- POST:
  - Each write decrements the post counter.
  - On the write that brings the counter to 0, go to DONE with cause 01.
  - Total entries stored after the trigger, including the trigger entry, equal POST.
- Halt:
  - The halt counter increments when pc_in==prev_pc and a prior sample exists in this run; otherwise it clears.
  - When it reaches HALT_CNT-1, that sample is written and the block goes to DONE with cause 10.
  - Halt is checked in both ARMED and POST.
- Timeout:
  - With TIMEOUT!=0, the write that makes cycles==TIMEOUT goes to DONE with cause 11.
- Simultaneous stop conditions, highest priority first:
  - POST completion (01), then halt (10), then timeout (11).
  - A trigger and a halt in the same ARMED cycle with POST>1: the trigger is accepted, then halt stops the run (cause 10).
  - The sample in the stopping cycle is always written.
- Readout:
  - Combinational: entry = buf[(wr_ptr - fill + rd_idx) mod DEPTH].
  - rd_idx >= fill returns all-zero outputs.
  - Contents are stable in IDLE and DONE.
  - Readout during ARMED/POST returns pre-edge contents.
- done is combinational from state.

Test Plan:
1. Reset:
   - Stimulus: assert reset 2 cycles with start=1.
   - Response: state=0, fill=0, cycles=0, stop_cause=00, done=0; rd_idx=0 returns 0.
2. Trigger with wrap:
   - Stimulus: start; pc_in=(n-1)*4 for sample n; trig_en=1; trig_pc=0x40 (sample 17).
   - Response: DONE after sample 24; stop_cause=01; cycles=24; fill=16.
   - Readout: rd_idx0 pc=0x20, rd_idx8 pc=0x40, rd_idx15 pc=0x5C.
3. Halt:
   - Stimulus: pc sequence 0,4,8,8,8,8.
   - Response: DONE after sample 6; stop_cause=10; fill=6; rd_idx5 pc=0x8; rd_idx6 returns 0.
4. Timeout:
   - Stimulus: trig_en=0; pc incrementing by 4.
   - Response: DONE after sample 2500; stop_cause=11; cycles=2500; fill=16; rd_idx15 pc=0x270C.
5. Precedence:
   - Stimulus: the PC sticks so that the halt condition coincides with the 8th post-trigger sample.
   - Response: stop_cause=01.
6. Reset mid-run and re-arm:
   - Stimulus: reset at sample 5; then start; then start again in DONE.
   - Response: after reset, state=0 and fill=0. After each start, cycles restarts at 1 and old fill is discarded. A start pulse while ARMED has no effect.

Source files
------------

// File: rtl/rv_trace_capture.sv
// rv_trace_capture: run controller and circular trace buffer for the RV32I core.
// Samples PC/opcode/ALU every cycle and stops on PC trigger, halt or timeout.
module rv_trace_capture #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int POST     = 8,
    parameter int TIMEOUT  = 2500,
    parameter int HALT_CNT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [31:0]                op_in,
    input  logic [XLEN-1:0]            alu_in,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_op,
    output logic [XLEN-1:0]            rd_alu,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic [1:0]                 state,
    output logic                       done,
    output logic [1:0]                 stop_cause,
    output logic [31:0]                cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(POST + 1);
    localparam int HW = $clog2(HALT_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_TRIG = 2'd1;
    localparam logic [1:0] C_HALT = 2'd2;
    localparam logic [1:0] C_TMO  = 2'd3;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [31:0]     cycles_q, cycles_d;
    logic [1:0]      cause_q, cause_d;
    logic [PW-1:0]   post_cnt_q, post_cnt_d;
    logic [HW-1:0]   halt_cnt_q, halt_cnt_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic            wr_en;

    logic [XLEN-1:0] mem_pc_q  [DEPTH];
    logic [31:0]     mem_op_q  [DEPTH];
    logic [XLEN-1:0] mem_alu_q [DEPTH];

    logic [31:0]   cyc_inc;
    logic          trig_hit;
    logic          same_pc;
    logic [HW-1:0] halt_nxt;
    logic          halt_hit;
    logic          tmo_hit;
    logic          post_done;

    always_comb begin
        cyc_inc   = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        trig_hit  = trig_en && (pc_in == trig_pc);
        // cycles_q is nonzero exactly when this run already holds a sample
        same_pc   = (cycles_q != 32'd0) && (pc_in == prev_pc_q);
        halt_nxt  = same_pc ? halt_cnt_q + HW'(1) : '0;
        halt_hit  = same_pc && (halt_nxt == HW'(HALT_CNT - 1));
        tmo_hit   = (TIMEOUT != 0) && (cyc_inc == 32'(TIMEOUT));
        post_done = 1'b0;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        cycles_d   = cycles_q;
        cause_d    = cause_q;
        post_cnt_d = post_cnt_q;
        halt_cnt_d = halt_cnt_q;
        prev_pc_d  = prev_pc_q;
        wr_en      = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ARMED;
                    wr_ptr_d   = '0;
                    fill_d     = '0;
                    cycles_d   = '0;
                    cause_d    = C_NONE;
                    post_cnt_d = '0;
                    halt_cnt_d = '0;
                end
            end
            S_ARMED, S_POST: begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fill_d     = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);
                cycles_d   = cyc_inc;
                prev_pc_d  = pc_in;
                halt_cnt_d = halt_nxt;

                if (state_q == S_ARMED) begin
                    if (trig_hit) begin
                        if (POST == 1) begin
                            post_done = 1'b1;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = PW'(POST - 1);
                        end
                    end
                end else begin
                    post_cnt_d = post_cnt_q - PW'(1);
                    post_done  = (post_cnt_q == PW'(1));
                end

                // a trigger accepted this cycle can still be overridden by halt/timeout
                if (post_done) begin
                    state_d = S_DONE;
                    cause_d = C_TRIG;
                end else if (halt_hit) begin
                    state_d = S_DONE;
                    cause_d = C_HALT;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    cause_d = C_TMO;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            cycles_q   <= '0;
            cause_q    <= C_NONE;
            post_cnt_q <= '0;
            halt_cnt_q <= '0;
            prev_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            cycles_q   <= cycles_d;
            cause_q    <= cause_d;
            post_cnt_q <= post_cnt_d;
            halt_cnt_q <= halt_cnt_d;
            prev_pc_q  <= prev_pc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_pc_q[wr_ptr_q]  <= pc_in;
            mem_op_q[wr_ptr_q]  <= op_in;
            mem_alu_q[wr_ptr_q] <= alu_in;
        end
    end

    logic [AW-1:0] rd_addr;
    logic          rd_hit;

    always_comb begin
        rd_addr = wr_ptr_q - fill_q[AW-1:0] + rd_idx;
        rd_hit  = FW'(rd_idx) < fill_q;
        rd_pc   = rd_hit ? mem_pc_q[rd_addr] : '0;
        rd_op   = rd_hit ? mem_op_q[rd_addr] : '0;
        rd_alu  = rd_hit ? mem_alu_q[rd_addr] : '0;
    end

    assign fill       = fill_q;
    assign state      = state_q;
    assign done       = (state_q == S_DONE);
    assign stop_cause = cause_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_rv_trace_capture.sv
// Self-checking bench for rv_trace_capture: directed tables, corner
// sequences and random stimulus against a sample-history reference model.
module tb_rv_trace_capture;
    localparam int DEPTH    = 16;
    localparam int POST     = 8;
    localparam int TIMEOUT  = 2500;
    localparam int HALT_CNT = 4;

    logic        clock = 1'b0;
    logic        reset, start, trig_en;
    logic [31:0] trig_pc, pc_in, op_in, alu_in;
    logic [3:0]  rd_idx;
    logic [31:0] rd_pc, rd_op, rd_alu;
    logic [4:0]  fill;
    logic [1:0]  state, stop_cause;
    logic        done;
    logic [31:0] cycles;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    rv_trace_capture #(
        .XLEN(32), .DEPTH(DEPTH), .POST(POST),
        .TIMEOUT(TIMEOUT), .HALT_CNT(HALT_CNT)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .trig_en(trig_en), .trig_pc(trig_pc),
        .pc_in(pc_in), .op_in(op_in), .alu_in(alu_in),
        .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_op(rd_op), .rd_alu(rd_alu),
        .fill(fill), .state(state), .done(done),
        .stop_cause(stop_cause), .cycles(cycles)
    );

    function automatic logic [31:0] op_of(input logic [31:0] p);
        return p ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] p);
        return p * 32'd3 + 32'd1;
    endfunction

    task automatic set_pc(input logic [31:0] p);
        pc_in  = p;
        op_in  = op_of(p);
        alu_in = alu_of(p);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic st_chk(input string name, input int st, input int fl,
                          input int cyc, input int cause);
        chk({name, "_state"}, 32'(state), 32'(st));
        chk({name, "_done"}, 32'(done), 32'(st == 3));
        chk({name, "_fill"}, 32'(fill), 32'(fl));
        chk({name, "_cycles"}, cycles, 32'(cyc));
        chk({name, "_cause"}, 32'(stop_cause), 32'(cause));
    endtask

    task automatic rd_chk(input string name, input int idx, input bit vld,
                          input logic [31:0] p);
        rd_idx = 4'(idx);
        #1;
        chk({name, "_pc"}, rd_pc, vld ? p : 32'd0);
        chk({name, "_op"}, rd_op, vld ? op_of(p) : 32'd0);
        chk({name, "_alu"}, rd_alu, vld ? alu_of(p) : 32'd0);
    endtask

    // Reference model: keeps the last DEPTH samples of the run and
    // decides stops from the history itself.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] op;
        logic [31:0] alu;
    } smp_t;

    smp_t hist[$];
    int   m_state = 0;
    int   m_cause = 0;
    int   m_cyc   = 0;
    int   m_trig  = -1;

    task automatic model_step();
        bit post_ok, halt_ok;
        smp_t s;
        if (reset) begin
            m_state = 0; m_cause = 0; m_cyc = 0; m_trig = -1;
            hist.delete();
        end else if (m_state == 0 || m_state == 3) begin
            if (start) begin
                m_state = 1; m_cause = 0; m_cyc = 0; m_trig = -1;
                hist.delete();
            end
        end else begin
            m_cyc++;
            s.pc = pc_in; s.op = op_in; s.alu = alu_in;
            hist.push_back(s);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (m_state == 1 && trig_en && pc_in == trig_pc) begin
                m_trig  = m_cyc;
                m_state = 2;
            end
            post_ok = (m_trig > 0) && (m_cyc - m_trig + 1 == POST);
            halt_ok = (m_cyc >= HALT_CNT);
            if (halt_ok)
                for (int k = 1; k < HALT_CNT; k++)
                    if (hist[hist.size() - 1 - k].pc != pc_in) halt_ok = 0;
            if (post_ok) begin
                m_state = 3; m_cause = 1;
            end else if (halt_ok) begin
                m_state = 3; m_cause = 2;
            end else if (m_cyc == TIMEOUT) begin
                m_state = 3; m_cause = 3;
            end
        end
    endtask

    typedef struct {
        logic        start;
        logic [31:0] pc;
        int          idx;
        int          st;
        int          fl;
        int          cyc;
        int          cause;
        bit          vld;
        logic [31:0] rpc;
    } vec_t;

    vec_t tbl[8];
    logic [31:0] seq5[10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0, 0, 1, 0, 0, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0, 0, 1, 1, 1, 0, 1'b1, 32'h0};
        tbl[2] = '{1'b0, 32'h4, 0, 1, 2, 2, 0, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h8, 0, 1, 3, 3, 0, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h8, 0, 1, 4, 4, 0, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'h8, 0, 1, 5, 5, 0, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 32'h8, 5, 3, 6, 6, 2, 1'b1, 32'h8};
        tbl[7] = '{1'b0, 32'h0, 6, 3, 6, 6, 2, 1'b0, 32'h0};
        seq5 = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h100,
                 32'h10C, 32'h200, 32'h200, 32'h200, 32'h200};

        // reset with start held
        reset = 1; start = 1; trig_en = 0; trig_pc = 0; rd_idx = 0;
        set_pc(0);
        tick(); tick();
        st_chk("reset", 0, 0, 0, 0);
        rd_chk("reset_rd", 0, 0, 32'h0);
        reset = 0; start = 0;
        tick();

        // halt sequence 0,4,8,8,8,8
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start;
            set_pc(tbl[i].pc);
            tick();
            st_chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].fl,
                   tbl[i].cyc, tbl[i].cause);
            rd_chk($sformatf("tbl%0d_rd", i), tbl[i].idx, tbl[i].vld, tbl[i].rpc);
        end

        // trigger at sample 17 with wrap
        start = 1; tick(); start = 0;
        st_chk("t2_arm", 1, 0, 0, 0);
        trig_en = 1; trig_pc = 32'h40;
        for (int n = 1; n <= 24; n++) begin
            set_pc(32'((n - 1) * 4));
            tick();
            if (n == 16) chk("t2_pre_trig", 32'(state), 32'd1);
            if (n == 23) chk("t2_post", 32'(state), 32'd2);
        end
        trig_en = 0;
        st_chk("t2_done", 3, 16, 24, 1);
        rd_chk("t2_rd0", 0, 1, 32'h20);
        rd_chk("t2_rd8", 8, 1, 32'h40);
        rd_chk("t2_rd15", 15, 1, 32'h5C);

        // timeout
        start = 1; tick(); start = 0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            set_pc(32'((n - 1) * 4));
            tick();
            if (n == TIMEOUT - 1) chk("t4_pre", 32'(state), 32'd1);
        end
        st_chk("t4_done", 3, 16, 2500, 3);
        rd_chk("t4_rd15", 15, 1, 32'h270C);
        rd_chk("t4_rd0", 0, 1, 32'h26D0);

        // post completion coincides with halt
        start = 1; tick(); start = 0;
        trig_en = 1; trig_pc = 32'h100;
        for (int i = 0; i < 10; i++) begin
            set_pc(seq5[i]);
            tick();
            if (i == 8) chk("t5_post", 32'(state), 32'd2);
        end
        trig_en = 0;
        st_chk("t5_done", 3, 10, 10, 1);
        rd_chk("t5_rd2", 2, 1, 32'h100);
        rd_chk("t5_rd9", 9, 1, 32'h200);

        // reset mid-run, re-arm, start ignored while armed, restart from DONE
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h300 + 32'(i * 4));
            tick();
        end
        reset = 1; set_pc(32'h310); tick(); reset = 0;
        st_chk("t6_rst", 0, 0, 0, 0);
        start = 1; tick(); start = 0;
        st_chk("t6_arm", 1, 0, 0, 0);
        set_pc(32'h400); tick();
        st_chk("t6_s1", 1, 1, 1, 0);
        set_pc(32'h404); tick();
        start = 1; set_pc(32'h408); tick(); start = 0;
        st_chk("t6_s3", 1, 3, 3, 0);
        rd_chk("t6_rd0", 0, 1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h50);
            tick();
        end
        st_chk("t6_halt", 3, 7, 7, 2);
        start = 1; tick(); start = 0;
        st_chk("t6_rearm", 1, 0, 0, 0);
        set_pc(32'h600); tick();
        st_chk("t6_r1", 1, 1, 1, 0);
        rd_chk("t6_r1_rd0", 0, 1, 32'h600);
        rd_chk("t6_r1_rd1", 1, 0, 32'h0);

        // random stimulus against the model
        reset = 1; start = 0;
        model_step(); tick();
        reset = 0;
        for (int c = 0; c < 4000; c++) begin
            int ri;
            smp_t e;
            reset   = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 7) == 0);
            trig_en = $urandom_range(0, 1);
            trig_pc = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) != 0) set_pc(32'($urandom_range(0, 15) * 4));
            model_step();
            tick();
            ri = $urandom_range(0, DEPTH - 1);
            rd_idx = 4'(ri);
            #1;
            chk("rnd_state", 32'(state), 32'(m_state));
            chk("rnd_done", 32'(done), 32'(m_state == 3));
            chk("rnd_cause", 32'(stop_cause), 32'(m_cause));
            chk("rnd_cycles", cycles, 32'(m_cyc));
            chk("rnd_fill", 32'(fill), 32'(hist.size()));
            if (ri < hist.size()) e = hist[ri];
            else begin e.pc = 0; e.op = 0; e.alu = 0; end
            chk("rnd_rd_pc", rd_pc, e.pc);
            chk("rnd_rd_op", rd_op, e.op);
            chk("rnd_rd_alu", rd_alu, e.alu);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
